// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: FSM state encoding and default operand width for seq_mult
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SEQ_MULT_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: IDLE/RUN/DONE sequencer and RUN-cycle bit counter for seq_mult
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  output logic load,
  output logic step,
  output logic last,
  output logic finish,
  output logic busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t st, nxt;
  logic [CW-1:0] cnt;
  assign load   = (st == IDLE) && start;
  assign step   = (st == RUN);
  assign last   = step && (cnt == CW'(WIDTH - 1));
  assign finish = (st == DONE);
  assign busy   = (st != IDLE);
  // State register; a low RST returns to IDLE and drops any request seen with it
  always_ff @(posedge CLK)
    st <= !RST ? IDLE : nxt;
  // Next state: start is only honoured in IDLE, RUN always spans WIDTH cycles
  always_comb begin
    nxt = st;
    nxt = (st == IDLE) ? (start ? RUN : IDLE) : (st == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  // Bit counter: cleared on accept, advances once per RUN cycle
  always_ff @(posedge CLK)
    if (!RST || load) cnt <= '0;
    else if (step) cnt <= cnt + CW'(1);
endmodule

// File: rtl/seq_mult.sv
// seq_mult: shift-and-add multiplier, WIDTH+1 cycle latency; SEQ_MULT_SIGNED_EN selects two's-complement operands
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic load, step, last, finish, sub;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0] mplier;
  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .CLK(CLK), .RST(RST), .start(start),
    .load(load), .step(step), .last(last), .finish(finish), .busy(busy)
  );
  // Top multiplier bit carries negative weight in the signed build
  assign sub = SGN && last;
  // Operand capture and one partial product per RUN cycle, LSB of the multiplier first
  always_ff @(posedge CLK)
    if (!RST) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{SGN && A[WIDTH-1]}}, A};
      mplier <= B;
      acc    <= '0;
    end else if (step) begin
      acc    <= mplier[0] ? (sub ? acc - mcand : acc + mcand) : acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  // Result register and one-cycle done pulse on leaving DONE
  always_ff @(posedge CLK)
    if (!RST) begin
      product <= '0;
      done    <= 1'b0;
    end else begin
      product <= finish ? acc : product;
      done    <= finish;
    end
endmodule
